button_bounce_gen: RTL and testbench
====================================

BUTTON_BOUNCE_GEN -- requirements
Module: button_bounce_gen

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- GAP_W, 5: width of the random inter-edge gap field.
- SETTLE, 20: number of stable cycles after the final edge before completion.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, input, 1: single clock; all state changes on its rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- start, input, 1: request one bounce sequence; sampled at clk rising edge.
- target, input, 1: final settled level requested; sampled with start.
- n_bounces, input, 3: bounce count requested, 0..7; sampled with start.
- seed_load, input, 1: load LFSR from seed this cycle.
- seed, input, 16: LFSR seed value.
- button, output, 1: emulated mechanical contact level; registered.
- busy, output, 1: sequence in progress; registered.
- done, output, 1: one-cycle completion pulse; registered.

Function
REQ-003 The block SHALL implement FSM states IDLE, BOUNCE and SETTLE.
REQ-004 The block SHALL advance a 16-bit Fibonacci LFSR every cycle, polynomial x^16+x^14+x^13+x^11+1, shifting left with the feedback bit entering bit 0.
REQ-005 On seed_load=1 the LFSR SHALL load seed in that cycle (overriding the advance); seed=0x0000 SHALL load 0xACE1 instead.
REQ-006 In IDLE, start=1 SHALL be accepted; target and n_bounces SHALL be latched and busy SHALL go 1 at the same edge.
REQ-007 If target != button at acceptance, button SHALL toggle at the accepting edge (first edge).
- Total toggles for the sequence SHALL be exactly 2*n_bounces+1.
- The final level SHALL equal target.
REQ-008 If n_bounces=0 (and target != button), the single toggle SHALL occur and the FSM SHALL go directly to SETTLE.
- Otherwise the FSM SHALL go to BOUNCE.
REQ-009 If target == button at acceptance, no toggle SHALL occur and the FSM SHALL go directly to SETTLE.
REQ-010 At each toggle edge the block SHALL capture g = LFSR[GAP_W-1:0] (value before that edge's advance).
- The next toggle SHALL occur exactly g+1 cycles later (1..2^GAP_W).
REQ-011 After the final toggle the FSM SHALL enter SETTLE, with button held stable.
REQ-012 SETTLE SHALL last exactly SETTLE cycles, after which done=1 for one cycle, busy=0 at that same edge, and the FSM SHALL return to IDLE.
REQ-013 start while busy=1 SHALL be ignored with no effect on the sequence in progress.
REQ-014 start in the same cycle that done=1 SHALL be ignored; a new start is accepted from the following cycle.
REQ-015 Edge and gap counters SHALL be sized for the maximum counts (edges up to 15, gaps up to 2^GAP_W, settle up to SETTLE) and SHALL never wrap.
REQ-016 seed_load during BOUNCE SHALL affect only gaps captured at later toggles.

Reset
REQ-017 rst_n=0 SHALL immediately, without waiting for a clock edge, force:
- button=0, busy=0, done=0;
- FSM=IDLE, LFSR=0xACE1, all counters=0.
REQ-018 Reset asserted mid-sequence SHALL abort the sequence with no done pulse.
REQ-019 After rst_n deasserts, the first start SHALL be accepted at the first rising clk edge with rst_n=1.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset: rst_n=0 mid-BOUNCE -> button=0, busy=0, done=0 before the next clk edge; no done afterward; next start accepted normally.
- Seeded sequence: seed_load with seed=0x0001, then start, target=1, n_bounces=2 -> exactly 5 toggles, first at the accepting edge, gaps equal to a reference LFSR model, button=1 stable 20 cycles, then a one-cycle done with busy falling at the same edge.
- Single toggle: start, target=1, n_bounces=0, button=0 -> one toggle at the accepting edge, done exactly 20 cycles later.
- No-op level: start, target=0, button=0 -> no toggles, busy high 20 cycles, then done.
- Ignored starts: start pulsed during BOUNCE, and in the done cycle -> toggle count and timing unchanged; no extra sequence.
- Zero seed: seed_load with seed=0x0000 -> LFSR reads 0xACE1; max-gap case (LFSR low bits all 1) gives a gap of 32 cycles.

Source files
------------

// File: rtl/button_bounce_gen.sv
// Emulates a bouncing mechanical contact: after a start request the output toggles
// 2*n_bounces+1 times at LFSR-random gaps, holds for SETTLE cycles, then pulses done.
module button_bounce_gen #(
    parameter int GAP_W  = 5,
    parameter int SETTLE = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        target,
    input  logic [2:0]  n_bounces,
    input  logic        seed_load,
    input  logic [15:0] seed,
    output logic        button,
    output logic        busy,
    output logic        done
);
    localparam int GCW = GAP_W + 1;
    localparam int SCW = $clog2(SETTLE + 1);
    localparam logic [15:0] LFSR_INIT = 16'hACE1;

    typedef enum logic [1:0] {ST_IDLE, ST_BOUNCE, ST_SETTLE} state_t;

    state_t         state, state_n;
    logic [15:0]    lfsr, lfsr_n;
    logic [3:0]     edges, edges_n;
    logic [GCW-1:0] gap, gap_n, gap_cap;
    logic [SCW-1:0] settle, settle_n;
    logic           target_q, target_n;
    logic           button_n, busy_n, done_n;
    logic           fb;

    assign fb      = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    // Gap counter holds g+1 so the next toggle lands exactly g+1 cycles later.
    assign gap_cap = GCW'(lfsr[GAP_W-1:0]) + GCW'(1);

    always_comb begin
        lfsr_n = {lfsr[14:0], fb};
        if (seed_load)
            lfsr_n = (seed == 16'h0000) ? LFSR_INIT : seed;
    end

    always_comb begin
        state_n  = state;
        button_n = button;
        busy_n   = busy;
        done_n   = 1'b0;
        target_n = target_q;
        edges_n  = edges;
        gap_n    = gap;
        settle_n = settle;
        case (state)
            ST_IDLE: begin
                // The done cycle is still IDLE, so a start there must be masked.
                if (start && !done) begin
                    target_n = target;
                    busy_n   = 1'b1;
                    if (target != button) begin
                        button_n = target;
                        if (n_bounces == 3'd0) begin
                            state_n  = ST_SETTLE;
                            settle_n = SCW'(SETTLE);
                        end else begin
                            state_n = ST_BOUNCE;
                            edges_n = {n_bounces, 1'b0};
                            gap_n   = gap_cap;
                        end
                    end else begin
                        state_n  = ST_SETTLE;
                        settle_n = SCW'(SETTLE);
                    end
                end
            end
            ST_BOUNCE: begin
                if (gap == GCW'(1)) begin
                    edges_n = edges - 4'd1;
                    if (edges == 4'd1) begin
                        button_n = target_q;
                        state_n  = ST_SETTLE;
                        settle_n = SCW'(SETTLE);
                        gap_n    = '0;
                    end else begin
                        button_n = ~button;
                        gap_n    = gap_cap;
                    end
                end else begin
                    gap_n = gap - GCW'(1);
                end
            end
            ST_SETTLE: begin
                if (settle == SCW'(1)) begin
                    done_n   = 1'b1;
                    busy_n   = 1'b0;
                    state_n  = ST_IDLE;
                    settle_n = '0;
                end else begin
                    settle_n = settle - SCW'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            lfsr     <= LFSR_INIT;
            edges    <= '0;
            gap      <= '0;
            settle   <= '0;
            target_q <= 1'b0;
            button   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            lfsr     <= lfsr_n;
            edges    <= edges_n;
            gap      <= gap_n;
            settle   <= settle_n;
            target_q <= target_n;
            button   <= button_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end
endmodule

// File: tb/tb_button_bounce_gen.sv
// Bench for button_bounce_gen: event-time reference model checked every cycle plus directed literal checks.
module tb_button_bounce_gen;
    localparam int GAP_W  = 5;
    localparam int SETTLE = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        target = 1'b0;
    logic [2:0]  n_bounces = 3'd0;
    logic        seed_load = 1'b0;
    logic [15:0] seed = 16'h0000;
    logic        button, busy, done;

    button_bounce_gen #(.GAP_W(GAP_W), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .target(target),
        .n_bounces(n_bounces), .seed_load(seed_load), .seed(seed),
        .button(button), .busy(busy), .done(done)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int tog_q[$];
    int done_cyc = -1;

    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
    end

    // Reference model: absolute event times instead of countdowns.
    logic [15:0] m_lfsr = 16'hACE1;
    logic [15:0] m_acc_lfsr = 16'h0000;
    logic        m_button = 1'b0, m_busy = 1'b0, m_done = 1'b0;
    int          m_left = 0, m_next = 0, m_done_at = 0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    initial forever begin
        logic [15:0] pre;
        logic        was_done;
        int          now;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_lfsr = 16'hACE1; m_button = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
        end else begin
            now = cyc; pre = m_lfsr; was_done = m_done; m_done = 1'b0;
            if (!m_busy && start && !was_done) begin
                m_busy = 1'b1; m_acc_lfsr = pre;
                if (target != m_button) begin
                    m_left = 2 * int'(n_bounces) + 1;
                    m_next = now;
                end else begin
                    m_done_at = now + SETTLE;
                end
            end else if (m_busy && m_left == 0 && now == m_done_at) begin
                m_done = 1'b1; m_busy = 1'b0;
            end
            if (m_busy && m_left > 0 && now == m_next) begin
                m_button = ~m_button;
                m_left--;
                if (m_left == 0) m_done_at = now + SETTLE;
                else             m_next = now + int'(pre[GAP_W-1:0]) + 1;
            end
            m_lfsr = seed_load ? ((seed == 16'h0000) ? 16'hACE1 : seed) : lfsr_step(m_lfsr);
        end
    end

    initial begin
        logic prev_btn;
        prev_btn = 1'b0;
        forever begin
            @(negedge clk);
            n_checks++;
            if ({button, busy, done} !== {m_button, m_busy, m_done}) begin
                n_fail++;
                $display("FAIL cycle_compare @%0d: button/busy/done got %b%b%b expected %b%b%b",
                         cyc, button, busy, done, m_button, m_busy, m_done);
            end
            if (button !== prev_btn) tog_q.push_back(cyc);
            prev_btn = button;
            if (done) done_cyc = cyc;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int tog_off(input int i, input int acc);
        return (i < tog_q.size()) ? tog_q[i] - acc : -1;
    endfunction

    task automatic run_seq(input logic tgt, input logic [2:0] nb, input int pulse_at,
                           input bit pulse_done, output int acc, output int dcyc);
        bit seen;
        @(negedge clk);
        rst_n = 1'b1; seed_load = 1'b0; tog_q.delete(); done_cyc = -1;
        start = 1'b1; target = tgt; n_bounces = nb;
        @(negedge clk);
        start = 1'b0; acc = cyc; seen = 1'b0;
        for (int k = 1; k <= 3000 && !seen; k++) begin
            @(negedge clk);
            start = (k == pulse_at);
            if (done) seen = 1'b1;
        end
        dcyc = cyc;
        check("seq_done_seen", int'(seen), 1);
        start = seen && pulse_done;
        @(negedge clk);
        start = 1'b0;
        if (pulse_done) check("start_in_done_ignored", int'(busy), 0);
    endtask

    int exp_seeded[5] = '{0, 2, 7, 8, 9};
    int exp_zero[3]   = '{0, 2, 10};

    initial begin
        int acc, dcyc;
        #2;
        check("reset_outputs", int'({button, busy, done}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Level already matches: no toggles, done after SETTLE cycles.
        run_seq(1'b0, 3'd3, -1, 1'b0, acc, dcyc);
        check("noop_toggles", tog_q.size(), 0);
        check("noop_done_off", dcyc - acc, 20);

        run_seq(1'b1, 3'd0, -1, 1'b0, acc, dcyc);
        check("single_toggles", tog_q.size(), 1);
        check("single_first_off", tog_off(0, acc), 0);
        check("single_done_off", dcyc - acc, 20);

        // Starts during BOUNCE and in the done cycle must be ignored.
        run_seq(1'b0, 3'd3, 3, 1'b1, acc, dcyc);
        check("ignored_toggles", tog_q.size(), 7);
        check("ignored_settle", dcyc - tog_off(6, 0), 20);
        check("ignored_button", int'(button), 0);

        @(negedge clk); seed_load = 1'b1; seed = 16'h0001;
        run_seq(1'b1, 3'd2, -1, 1'b0, acc, dcyc);
        check("seeded_model_lfsr", int'(m_acc_lfsr), 16'h0001);
        check("seeded_toggles", tog_q.size(), 5);
        for (int i = 0; i < 5; i++) check($sformatf("seeded_tog%0d_off", i), tog_off(i, acc), exp_seeded[i]);
        check("seeded_done_off", dcyc - acc, 29);
        check("seeded_button", int'(button), 1);

        @(negedge clk); seed_load = 1'b1; seed = 16'h0000;
        run_seq(1'b0, 3'd1, -1, 1'b0, acc, dcyc);
        check("zero_seed_model_lfsr", int'(m_acc_lfsr), 16'hACE1);
        check("zero_seed_toggles", tog_q.size(), 3);
        for (int i = 0; i < 3; i++) check($sformatf("zero_seed_tog%0d_off", i), tog_off(i, acc), exp_zero[i]);
        check("zero_seed_done_off", dcyc - acc, 30);

        @(negedge clk); seed_load = 1'b1; seed = 16'h001F;
        run_seq(1'b1, 3'd1, -1, 1'b0, acc, dcyc);
        check("maxgap_toggles", tog_q.size(), 3);
        check("maxgap_gap", tog_off(1, acc) - tog_off(0, acc), 32);

        // Abort mid-BOUNCE with an asynchronous reset.
        @(negedge clk); start = 1'b1; target = 1'b0; n_bounces = 3'd7;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_before_reset", int'(busy), 1);
        @(posedge clk); #2; rst_n = 1'b0; #1;
        check("reset_async_outputs", int'({button, busy, done}), 0);
        done_cyc = -1;
        repeat (4) @(negedge clk);
        check("no_done_in_reset", done_cyc, -1);
        run_seq(1'b1, 3'd0, -1, 1'b0, acc, dcyc);
        check("post_reset_first_off", tog_off(0, acc), 0);
        check("post_reset_toggles", tog_q.size(), 1);
        check("post_reset_done_off", dcyc - acc, 20);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
